recepcao_serial_comandos: RTL and testbench
===========================================

// Module: recepcao_serial_comandos
// PURPOSE
//  UART receiver + command parser for the SmartCargo host link; inbound counterpart of the automatic serial sender.
//  Decodes 3-byte request packets {SYNC, DATA, CHECK} from RX into (tipo, origem, destino).
//  Writes each valid request into the elevator queue RAM through its weT write port.
//  Flags framing, checksum, invalid-command, timeout and queue-full errors.
// PARAMETERS
//  CLKS_PER_BIT   434   clock cycles per UART bit (>=4)
//  TIMEOUT_BYTES  4     max idle gap between packet bytes, in byte times (10*CLKS_PER_BIT each)
// PORTS
//  clock              in   1  system clock
//  reset              in   1  synchronous, active-high
//  RX                 in   1  UART serial input, idle high, asynchronous
//  tem_vaga_fila      in   1  queue RAM has a free slot
//  in_tipo_objeto     out  2  decoded object type to queue RAM
//  in_origem_objeto   out  2  decoded origin floor
//  in_destino_objeto  out  2  decoded destination floor
//  weT                out  1  one-cycle queue write strobe
//  erro_quadro        out  1  one-cycle pulse: stop bit (or parity) bad
//  erro_comando       out  1  one-cycle pulse: bad checksum, DATA[7:6]!=00, or origem==destino
//  erro_fila_cheia    out  1  one-cycle pulse: valid packet dropped, queue full
//  ocupado            out  1  packet in progress (parser not in ESPERA_SYNC)
// BEHAVIOUR
//  Reset: all outputs 0; in_* = 2'b00; RX sync flops = 1; both FSMs idle; counters 0.
//  RX through 2-flop synchroniser (2 cycles latency) before any use.
//  Byte FSM: OCIOSO -> START on falling edge; re-check at CLKS_PER_BIT/2, if high back to OCIOSO (glitch).
//   DADOS: 8 bits LSB-first, each sampled at mid-bit; STOP sampled mid-bit.
//   STOP=1 -> byte_ok pulse, 1 cycle; STOP=0 -> erro_quadro pulse, byte discarded; FSM returns to OCIOSO either way.
//  Packet FSM: ESPERA_SYNC -> (byte==8'h23) ESPERA_DADO -> ESPERA_CHECK -> VALIDA -> ESPERA_SYNC.
//   Non-SYNC bytes in ESPERA_SYNC silently ignored.
//   DATA = {2'b00, tipo[5:4], origem[3:2], destino[1:0]}; CHECK must equal DATA ^ 8'h5A.
//   VALIDA (1 cycle), checks in priority order:
//    1. command error -> erro_comando pulse;
//    2. else !tem_vaga_fila -> erro_fila_cheia pulse;
//    3. else weT=1 for exactly that cycle.
//   in_* updated at entry to VALIDA and held stable until the next packet's VALIDA.
//   Latency: weT asserted 1 cycle after byte_ok of CHECK byte.
//  Timeout: in ESPERA_DADO/ESPERA_CHECK, idle counter cleared on each byte_ok.
//   Reaching TIMEOUT_BYTES*10*CLKS_PER_BIT -> return to ESPERA_SYNC, no error pulse.
//  A framing error mid-packet aborts the packet: -> ESPERA_SYNC.
//  A byte arriving during VALIDA is not lost: its byte_ok is evaluated after VALIDA, in ESPERA_SYNC.
//  A second SYNC (0x23) in ESPERA_DADO is treated as DATA: no resync.
//  Reset mid-frame: everything returns to idle next cycle; a partial byte is dropped.
// CONFIGURATION
//  RX_PARIDADE_EN defined: frame 8E1; parity bit sampled between D7 and STOP; parity mismatch -> erro_quadro, byte discarded.
//  Not defined: frame 8N1, no parity sampling.
// STRUCTURE
//  Package serial_pkg: SYNC_BYTE=8'h23, CHK_MASK=8'h5A, byte-FSM and packet-FSM state encodings, bits-per-frame constant.
//  Sub-module rx_serial_byte: synchroniser + byte FSM + baud counter; outputs byte[7:0], byte_ok, erro_quadro.
//  Top: packet FSM, timeout counter, output registers.
// TESTING (bench: CLKS_PER_BIT=8, TIMEOUT_BYTES=2)
//  1. Send 23,1B,41 with tem_vaga_fila=1 -> one weT pulse; tipo=01, origem=10, destino=11.
//  2. Send 23,1B,40 -> erro_comando pulse, no weT. Send 23,15,4F (origem=destino=01) -> erro_comando.
//  3. Send 23,1B,41 with tem_vaga_fila=0 -> erro_fila_cheia pulse, no weT, in_* still updated.
//  4. Send byte 23 with STOP=0 -> erro_quadro; then 1B,41 -> ignored, no weT.
//  5. Send 23,1B, then idle 200 cycles, then 41 -> no weT, ocupado drops; next 23,1B,41 -> weT.
//  6. Pulse RX low for 2 cycles -> no byte_ok. Assert reset mid-DATA byte -> outputs 0; next full packet accepted.
//  7. RX_PARIDADE_EN build: byte with wrong even-parity bit -> erro_quadro.

Source files
------------

// File: rtl/recepcao_serial_comandos_pkg.sv
// serial_pkg: shared constants, FSM encodings and command validation for the host-link receiver.
package serial_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'h23;
    localparam logic [7:0] CHK_MASK = 8'h5A;
    localparam int BITS_POR_BYTE = 10;
    typedef enum logic [2:0] {OCIOSO, START, DADOS, PARIDADE, STOP} byte_st_t;
    typedef enum logic [1:0] {ESPERA_SYNC, ESPERA_DADO, ESPERA_CHECK, VALIDA} pkt_st_t;
    function automatic logic cmd_invalido(input logic [7:0] d, input logic [7:0] c);
        return (c != (d ^ CHK_MASK)) || (d[7:6] != 2'b00) || (d[3:2] == d[1:0]);
    endfunction
endpackage

// File: rtl/recepcao_serial_comandos_if.sv
// recepcao_serial_comandos_if: host-link serial input and queue-RAM request/status signals.
interface recepcao_serial_comandos_if;
    logic RX;
    logic tem_vaga_fila;
    logic [1:0] in_tipo_objeto;
    logic [1:0] in_origem_objeto;
    logic [1:0] in_destino_objeto;
    logic weT;
    logic erro_quadro;
    logic erro_comando;
    logic erro_fila_cheia;
    logic ocupado;
    modport master (
        output RX, tem_vaga_fila,
        input in_tipo_objeto, in_origem_objeto, in_destino_objeto, weT, erro_quadro, erro_comando, erro_fila_cheia, ocupado
    );
    modport slave (
        input RX, tem_vaga_fila,
        output in_tipo_objeto, in_origem_objeto, in_destino_objeto, weT, erro_quadro, erro_comando, erro_fila_cheia, ocupado
    );
endinterface

// File: rtl/recepcao_serial_comandos_rx_serial_byte.sv
// rx_serial_byte: RX synchroniser + UART byte FSM, 8N1 or 8E1 when RX_PARIDADE_EN is defined.
module rx_serial_byte
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] dado,
    output logic       byte_ok,
    output logic       erro_quadro
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    logic rx_m, rx_s, par_err;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    byte_st_t st;
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            st <= OCIOSO;
            cnt <= '0;
            idx <= '0;
            par_err <= 1'b0;
            dado <= '0;
            byte_ok <= 1'b0;
            erro_quadro <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            byte_ok <= 1'b0;
            erro_quadro <= 1'b0;
            cnt <= cnt + 1'b1;
            case (st)
                OCIOSO: begin
                    cnt <= '0;
                    if (!rx_s) st <= START;
                end
                // Half a bit in: a start bit that went high again was a glitch; otherwise all later samples land mid-bit.
                START: if (cnt == HALF) begin
                    cnt <= '0;
                    idx <= '0;
                    par_err <= 1'b0;
                    st <= rx_s ? OCIOSO : DADOS;
                end
                DADOS: if (cnt == FULL) begin
                    cnt <= '0;
                    dado <= {rx_s, dado[7:1]};
                    idx <= idx + 1'b1;
`ifdef RX_PARIDADE_EN
                    if (idx == 3'd7) st <= PARIDADE;
`else
                    if (idx == 3'd7) st <= STOP;
`endif
                end
                PARIDADE: if (cnt == FULL) begin
                    cnt <= '0;
                    par_err <= rx_s != ^dado;
                    st <= STOP;
                end
                STOP: if (cnt == FULL) begin
                    byte_ok <= rx_s && !par_err;
                    erro_quadro <= !rx_s || par_err;
                    st <= OCIOSO;
                end
                default: st <= OCIOSO;
            endcase
        end
    end
endmodule

// File: rtl/recepcao_serial_comandos.sv
// recepcao_serial_comandos: {SYNC,DATA,CHECK} packet parser writing valid requests to the queue RAM.
// Frame format set by RX_PARIDADE_EN inside rx_serial_byte (8E1 when defined, 8N1 otherwise).
module recepcao_serial_comandos
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BYTES = 4
) (
    input logic clock,
    input logic reset,
    recepcao_serial_comandos_if.slave bus
);
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_BYTES * BITS_POR_BYTE * CLKS_PER_BIT);
    logic [7:0] dado, data_reg;
    logic byte_ok, pend, bad, aborta;
    logic [31:0] tcnt;
    pkt_st_t st;
    rx_serial_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock(clock),
        .reset(reset),
        .rx(bus.RX),
        .dado(dado),
        .byte_ok(byte_ok),
        .erro_quadro(bus.erro_quadro)
    );
    assign bad = cmd_invalido(data_reg, dado);
    assign aborta = bus.erro_quadro || (tcnt == TO_LIM - 32'd1);
    assign bus.ocupado = st != ESPERA_SYNC;
    always_ff @(posedge clock) begin
        if (reset) begin
            st <= ESPERA_SYNC;
            data_reg <= '0;
            pend <= 1'b0;
            tcnt <= '0;
            bus.in_tipo_objeto <= '0;
            bus.in_origem_objeto <= '0;
            bus.in_destino_objeto <= '0;
            bus.weT <= 1'b0;
            bus.erro_comando <= 1'b0;
            bus.erro_fila_cheia <= 1'b0;
        end else begin
            bus.weT <= 1'b0;
            bus.erro_comando <= 1'b0;
            bus.erro_fila_cheia <= 1'b0;
            pend <= 1'b0;
            tcnt <= byte_ok ? '0 : tcnt + 32'd1;
            case (st)
                // pend replays a byte that completed during VALIDA.
                ESPERA_SYNC: begin
                    tcnt <= '0;
                    if ((byte_ok || pend) && dado == SYNC_BYTE) st <= ESPERA_DADO;
                end
                ESPERA_DADO: begin
                    if (byte_ok) begin
                        data_reg <= dado;
                        st <= ESPERA_CHECK;
                    end else if (aborta) st <= ESPERA_SYNC;
                end
                ESPERA_CHECK: begin
                    if (byte_ok) begin
                        st <= VALIDA;
                        bus.in_tipo_objeto <= data_reg[5:4];
                        bus.in_origem_objeto <= data_reg[3:2];
                        bus.in_destino_objeto <= data_reg[1:0];
                        bus.erro_comando <= bad;
                        bus.erro_fila_cheia <= !bad && !bus.tem_vaga_fila;
                        bus.weT <= !bad && bus.tem_vaga_fila;
                    end else if (aborta) st <= ESPERA_SYNC;
                end
                default: begin
                    pend <= byte_ok;
                    st <= ESPERA_SYNC;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_recepcao_serial_comandos.sv
// tb_recepcao_serial_comandos: packet vectors plus corner sequences, scoreboard of queue/error events.
module tb_recepcao_serial_comandos;
    localparam int CPB = 8;
    localparam logic [1:0] K_WE = 2'd0, K_CMD = 2'd1, K_FULL = 2'd2, K_QUAD = 2'd3;
    typedef struct {
        logic [1:0] kind;
        logic [1:0] tipo, orig, dest;
    } ev_t;
    typedef struct {
        logic [7:0] b0, b1, b2;
        logic vaga;
        logic [1:0] kind, tipo, orig, dest;
    } vec_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    ev_t sb[$];
    int checks = 0;
    int failures = 0;
    always #5 clock = ~clock;
    recepcao_serial_comandos_if bus();
    recepcao_serial_comandos #(.CLKS_PER_BIT(CPB), .TIMEOUT_BYTES(2)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic bit_out(input logic v);
        bus.RX = v;
        repeat (CPB) tick();
    endtask
    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef RX_PARIDADE_EN
        bit_out(^b);
`endif
        bit_out(stop);
        bit_out(1'b1);
    endtask
`ifdef RX_PARIDADE_EN
    task automatic send_par_bad(input logic [7:0] b);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(~^b);
        bit_out(1'b1);
        bit_out(1'b1);
    endtask
`endif
    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask
    task automatic push(input logic [1:0] k, input logic [1:0] t, input logic [1:0] o, input logic [1:0] d);
        ev_t e;
        e.kind = k;
        e.tipo = t;
        e.orig = o;
        e.dest = d;
        sb.push_back(e);
    endtask
    task automatic drain(input string name);
        repeat (20) tick();
        chk({name, "_pending"}, 8'(sb.size()), 8'd0);
        sb.delete();
    endtask
    always @(negedge clock) begin
        if (!reset && (bus.weT || bus.erro_comando || bus.erro_fila_cheia || bus.erro_quadro)) begin
            ev_t a, e;
            a.kind = bus.weT ? K_WE : bus.erro_comando ? K_CMD : bus.erro_fila_cheia ? K_FULL : K_QUAD;
            a.tipo = bus.in_tipo_objeto;
            a.orig = bus.in_origem_objeto;
            a.dest = bus.in_destino_objeto;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event kind=%0d expected=none", a.kind);
            end else begin
                e = sb.pop_front();
                chk("event_kind", 8'(a.kind), 8'(e.kind));
                if (e.kind == K_WE || e.kind == K_FULL) begin
                    chk("in_tipo", 8'(a.tipo), 8'(e.tipo));
                    chk("in_origem", 8'(a.orig), 8'(e.orig));
                    chk("in_destino", 8'(a.dest), 8'(e.dest));
                end
            end
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        vec_t v[8];
        v[0] = '{8'h23, 8'h1B, 8'h41, 1'b1, K_WE, 2'b01, 2'b10, 2'b11};
        v[1] = '{8'h23, 8'h1B, 8'h40, 1'b1, K_CMD, 2'b00, 2'b00, 2'b00};
        v[2] = '{8'h23, 8'h15, 8'h4F, 1'b1, K_CMD, 2'b00, 2'b00, 2'b00};
        v[3] = '{8'h23, 8'h1B, 8'h41, 1'b0, K_FULL, 2'b01, 2'b10, 2'b11};
        v[4] = '{8'h23, 8'hC6, 8'h9C, 1'b1, K_CMD, 2'b00, 2'b00, 2'b00};
        v[5] = '{8'h23, 8'h24, 8'h7E, 1'b1, K_WE, 2'b10, 2'b01, 2'b00};
        v[6] = '{8'h23, 8'h36, 8'h6C, 1'b1, K_WE, 2'b11, 2'b01, 2'b10};
        v[7] = '{8'h23, 8'h23, 8'h79, 1'b1, K_WE, 2'b10, 2'b00, 2'b11};
        bus.RX = 1'b1;
        bus.tem_vaga_fila = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_weT", 8'(bus.weT), 8'd0);
        chk("rst_erro_quadro", 8'(bus.erro_quadro), 8'd0);
        chk("rst_erro_comando", 8'(bus.erro_comando), 8'd0);
        chk("rst_erro_fila", 8'(bus.erro_fila_cheia), 8'd0);
        chk("rst_ocupado", 8'(bus.ocupado), 8'd0);
        chk("rst_in_tipo", 8'(bus.in_tipo_objeto), 8'd0);
        chk("rst_in_destino", 8'(bus.in_destino_objeto), 8'd0);
        reset = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 8; i++) begin
            bus.tem_vaga_fila = v[i].vaga;
            push(v[i].kind, v[i].tipo, v[i].orig, v[i].dest);
            send_pkt(v[i].b0, v[i].b1, v[i].b2);
            drain("vec");
        end
        bus.tem_vaga_fila = 1'b1;
        push(K_WE, 2'b10, 2'b01, 2'b00);
        send_byte(8'h55);
        send_pkt(8'h23, 8'h24, 8'h7E);
        drain("noise");
        push(K_QUAD, 2'b00, 2'b00, 2'b00);
        send_byte(8'h23, 1'b0);
        send_byte(8'h1B);
        send_byte(8'h41);
        drain("framing");
        send_byte(8'h23);
        send_byte(8'h1B);
        chk("to_ocupado_mid", 8'(bus.ocupado), 8'd1);
        repeat (200) tick();
        chk("to_ocupado_idle", 8'(bus.ocupado), 8'd0);
        send_byte(8'h41);
        drain("timeout");
        push(K_WE, 2'b01, 2'b10, 2'b11);
        send_pkt(8'h23, 8'h1B, 8'h41);
        drain("after_to");
        bus.RX = 1'b0;
        tick();
        tick();
        bus.RX = 1'b1;
        repeat (40) tick();
        chk("glitch_ocupado", 8'(bus.ocupado), 8'd0);
        push(K_WE, 2'b11, 2'b01, 2'b10);
        send_pkt(8'h23, 8'h36, 8'h6C);
        drain("glitch");
        send_byte(8'h23);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b1);
        bit_out(1'b0);
        reset = 1'b1;
        tick();
        chk("midrst_ocupado", 8'(bus.ocupado), 8'd0);
        chk("midrst_in_tipo", 8'(bus.in_tipo_objeto), 8'd0);
        chk("midrst_in_origem", 8'(bus.in_origem_objeto), 8'd0);
        chk("midrst_in_destino", 8'(bus.in_destino_objeto), 8'd0);
        bus.RX = 1'b1;
        reset = 1'b0;
        repeat (4 * CPB) tick();
        chk("midrst_ocupado_after", 8'(bus.ocupado), 8'd0);
        push(K_WE, 2'b01, 2'b10, 2'b11);
        send_pkt(8'h23, 8'h1B, 8'h41);
        drain("midrst");
`ifdef RX_PARIDADE_EN
        push(K_QUAD, 2'b00, 2'b00, 2'b00);
        send_par_bad(8'h23);
        drain("parity");
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
